// File: rtl/alu_div_seq.sv
// -----------------------------------------------------------------------------
// alu_div_seq
//   Multi-cycle integer divide sequencer (DIV/DIVU/REM/REMU, RISC-V M
//   semantics). It owns no divider datapath: every cycle it steers the core's
//   shared combinational ALU and captures ALU results back into its own
//   registers. The algorithm is restoring division on operand magnitudes,
//   with one compare cycle and one subtract cycle per quotient bit, followed
//   by sign fix-up of the quotient and the remainder.
//
//   Optional feature macro: ALU_DIV_ZERO_BYPASS_EN
//     When defined, a zero divisor skips the iteration and goes straight to
//     DONE. The result is the same (quotient all ones, remainder = dividend)
//     and the ALU is never driven.
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     flush              synchronous abort back to IDLE (beats in_valid)
//     in_valid/in_ready  request handshake (in_ready high only in IDLE)
//     in_signed          1 = DIV/REM, 0 = DIVU/REMU
//     in_dividend        dividend
//     in_divisor         divisor
//     out_valid/out_ready  response handshake (result held until accepted)
//     quotient/remainder result
//     busy               block owns the ALU (state != IDLE)
//     alu_op..alu_sign   ALU control/operand drive
//     alu_out, alu_zero  ALU result and zero flag
// -----------------------------------------------------------------------------
module alu_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_b_negate,
   output logic             alu_b_add_one,
   output logic             alu_sign,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_LTU = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE, S_NEG_A, S_NEG_B, S_CMP, S_SUB, S_FIX_Q, S_FIX_R, S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;      // dividend, then |dividend|, then quotient
   logic [WIDTH-1:0] r_rem;    // partial remainder
   logic [WIDTH-1:0] r_d;      // divisor, then |divisor|
   logic [CW-1:0]    r_cnt;    // quotient bit counter
   logic             r_sa;     // dividend negative (signed op only)
   logic             r_sb;     // divisor negative (signed op only)
   logic             r_dz;     // divide by zero
   logic             r_ge;     // shifted remainder >= divisor this bit
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [WIDTH-1:0] w_rsh;
   logic             w_neg_q;

   // Partial remainder shifted left with the next dividend bit brought in.
   assign w_rsh   = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
   // Quotient is negated only for differing signs; a zero divisor keeps all ones.
   assign w_neg_q = (r_sa ^ r_sb) & ~r_dz;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign quotient  = r_q;
   assign remainder = r_rem;
   assign alu_sign  = 1'b0;

   // ALU drive decoded from the state register. Negation is a + ~b + 1 with a = 0.
   always_comb begin
      alu_op        = OP_ADD;
      alu_a         = '0;
      alu_b         = '0;
      alu_b_negate  = 1'b0;
      alu_b_add_one = 1'b0;
      case (r_state)
         S_NEG_A: begin
`ifdef ALU_DIV_ZERO_BYPASS_EN
            if (!r_dz) begin
               alu_b         = r_q;
               alu_b_negate  = r_sa;
               alu_b_add_one = r_sa;
            end
`else
            alu_b         = r_q;
            alu_b_negate  = r_sa;
            alu_b_add_one = r_sa;
`endif
         end
         S_NEG_B: begin
            alu_b         = r_d;
            alu_b_negate  = r_sb;
            alu_b_add_one = r_sb;
         end
         S_CMP: begin
            alu_op = OP_LTU;
            alu_a  = w_rsh;
            alu_b  = r_d;
         end
         S_SUB: begin
            alu_a         = r_rem;
            alu_b         = r_d;
            alu_b_negate  = 1'b1;
            alu_b_add_one = 1'b1;
         end
         S_FIX_Q: begin
            alu_b         = r_q;
            alu_b_negate  = w_neg_q;
            alu_b_add_one = w_neg_q;
         end
         S_FIX_R: begin
            alu_b         = r_rem;
            alu_b_negate  = r_sa;
            alu_b_add_one = r_sa;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_q         <= '0;
         r_rem       <= '0;
         r_d         <= '0;
         r_cnt       <= '0;
         r_sa        <= 1'b0;
         r_sb        <= 1'b0;
         r_dz        <= 1'b0;
         r_ge        <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (flush) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_q        <= in_dividend;
                  r_d        <= in_divisor;
                  r_rem      <= '0;
                  r_cnt      <= '0;
                  r_ge       <= 1'b0;
                  r_sa       <= in_signed & in_dividend[WIDTH-1];
                  r_sb       <= in_signed & in_divisor[WIDTH-1];
                  r_dz       <= (in_divisor == '0);
                  r_state    <= S_NEG_A;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_NEG_A: begin
`ifdef ALU_DIV_ZERO_BYPASS_EN
               if (r_dz) begin
                  // r_q still holds the raw dividend here.
                  r_rem       <= r_q;
                  r_q         <= '1;
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_q     <= alu_out;
                  r_state <= S_NEG_B;
               end
`else
               r_q     <= alu_out;
               r_state <= S_NEG_B;
`endif
            end
            S_NEG_B: begin
               r_d     <= alu_out;
               r_state <= S_CMP;
            end
            S_CMP: begin
               // A bit shifted out of the remainder top means the true
               // (WIDTH+1)-bit value already exceeds any divisor.
               r_ge    <= r_rem[WIDTH-1] | alu_zero;
               r_rem   <= w_rsh;
               r_q     <= {r_q[WIDTH-2:0], 1'b0};
               r_state <= S_SUB;
            end
            S_SUB: begin
               if (r_ge) r_rem <= alu_out;
               r_q[0] <= r_ge;
               if (r_cnt == LAST_BIT) begin
                  r_cnt   <= '0;
                  r_state <= S_FIX_Q;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_CMP;
               end
            end
            S_FIX_Q: begin
               r_q     <= alu_out;
               r_state <= S_FIX_R;
            end
            S_FIX_R: begin
               r_rem       <= alu_out;
               r_state     <= S_DONE;
               r_out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_div_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_div_seq
//   Directed bench for alu_div_seq (WIDTH = 32) with a behavioural model of
//   the shared ALU (add with optional b negation, unsigned less-than).
// -----------------------------------------------------------------------------
module tb_alu_div_seq;

   localparam int W = 32;
`ifdef ALU_DIV_ZERO_BYPASS_EN
   localparam int DZ_LAT = 2;
`else
   localparam int DZ_LAT = 69;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_signed = 1'b0;
   logic [W-1:0]  in_dividend = '0;
   logic [W-1:0]  in_divisor = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          busy;
   logic [2:0]    alu_op;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic          alu_b_negate;
   logic          alu_b_add_one;
   logic          alu_sign;
   logic [W-1:0]  alu_out;
   logic          alu_zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_div_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
      .in_dividend(in_dividend), .in_divisor(in_divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .busy(busy),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_b_negate(alu_b_negate), .alu_b_add_one(alu_b_add_one),
      .alu_sign(alu_sign), .alu_out(alu_out), .alu_zero(alu_zero)
   );

   // Shared ALU model.
   logic [W-1:0] m_bx;
   always_comb begin
      m_bx = alu_b_negate ? ~alu_b : alu_b;
      if (alu_op == 3'b011) alu_out = {{(W-1){1'b0}}, (alu_a < alu_b)};
      else                  alu_out = alu_a + m_bx + {{(W-1){1'b0}}, alu_b_add_one};
      alu_zero = (alu_out == '0);
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, measure latency (acceptance edge counts as 1),
   // check the result, optionally stall out_ready for 10 cycles, then drain.
   task automatic run(input string tag, input logic sg, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] eq,
                      input logic [W-1:0] er, input int lat, input logic hold);
      int   cnt;
      logic ir_seen;
      @(negedge clk);
      in_valid = 1'b1; in_signed = sg; in_dividend = a; in_divisor = b;
      out_ready = ~hold;
      @(posedge clk);
      cnt = 1; ir_seen = 1'b0;
      #1 in_valid = 1'b0; in_dividend = 32'hDEAD_BEEF; in_divisor = 32'h1234_5678;
      @(negedge clk);
      while (!out_valid && cnt < 200) begin
         if (in_ready) ir_seen = 1'b1;
         @(posedge clk); cnt++;
         @(negedge clk);
      end
      chk({tag, " latency"}, cnt, lat);
      chk({tag, " quotient"}, quotient, eq);
      chk({tag, " remainder"}, remainder, er);
      chk({tag, " in_ready while busy"}, {31'b0, ir_seen | in_ready}, 32'd0);
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, " hold out_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, " hold quotient"}, quotient, eq);
            chk({tag, " hold remainder"}, remainder, er);
            chk({tag, " hold in_ready"}, {31'b0, in_ready}, 32'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      chk({tag, " drained out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, " drained in_ready"}, {31'b0, in_ready}, 32'd1);
      chk({tag, " drained busy"}, {31'b0, busy}, 32'd0);
   endtask

   // Watch 80 cycles for a spurious out_valid after an abort.
   task automatic quiet(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk({tag, " no out_valid"}, {31'b0, seen}, 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst quotient", quotient, 32'd0);
      chk("rst remainder", remainder, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle alu_op", {29'b0, alu_op}, 32'd0);
      chk("idle alu_a", alu_a, 32'd0);
      chk("idle alu_b", alu_b, 32'd0);
      chk("idle alu_neg", {30'b0, alu_b_negate, alu_b_add_one}, 32'd0);
      chk("alu_sign", {31'b0, alu_sign}, 32'd0);

      // Directed divides
      run("divu 100/7",   1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        69, 1'b0);
      run("div -7/2",     1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 69, 1'b0);
      run("div 7/-2",     1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        69, 1'b0);
      run("div ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        69, 1'b0);
      run("divu max/1",   1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        69, 1'b0);
      run("divu 2^31/3",  1'b0, 32'h8000_0000,  32'd3,        32'h2AAA_AAAA, 32'd2,        69, 1'b0);
      run("div -100/-7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 69, 1'b0);
      run("div -5/0",     1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, DZ_LAT, 1'b0);
      run("divu 9/0",     1'b0, 32'd9,          32'd0,        32'hFFFF_FFFF, 32'd9,        DZ_LAT, 1'b0);

      // Result held while out_ready is low
      run("hold 1000/33", 1'b0, 32'd1000,       32'd33,       32'd30,        32'd10,       69, 1'b1);

      // Flush mid-operation, with a competing in_valid on the flush cycle
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd500; in_divisor = 32'd3;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (29) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush busy", {31'b0, busy}, 32'd0);
      chk("flush in_ready", {31'b0, in_ready}, 32'd1);
      chk("flush out_valid", {31'b0, out_valid}, 32'd0);
      quiet("flush");
      run("after flush 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 69, 1'b0);

      // Asynchronous reset mid-operation
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b1; in_dividend = 32'd77; in_divisor = 32'd5;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (29) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst busy", {31'b0, busy}, 32'd0);
      chk("arst in_ready", {31'b0, in_ready}, 32'd1);
      chk("arst quotient", quotient, 32'd0);
      chk("arst remainder", remainder, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      quiet("arst");
      run("after arst 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 69, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
